// File: rtl/dcache_write_buffer.sv
// dcache_write_buffer
//   Posted-write line buffer between the d-cache memory port and the arbiter
//   d-port. Dirty evictions are absorbed into a small circular FIFO so the
//   cache sees a one-cycle write completion. Line reads that hit a buffered
//   entry are answered from the buffer. Line reads that miss go downstream
//   ahead of any pending drain. Buffered lines drain whenever the downstream
//   port is otherwise idle.
//
// Parameters
//   DEPTH         number of 256-bit entries (power of two, >= 2)
//
// Ports
//   clk, rst      clock; asynchronous active-low reset
//   mem_*         cache side: address/read/write/wdata in, rdata/resp out
//   pmem_*        arbiter side: address/read/write/wdata out, rdata/resp in
//   empty         nothing buffered and downstream FSM idle
//
// Optional build macro
//   DCACHE_WRITE_BUFFER_PERF_EN adds saturating counters read_hit_cnt,
//   full_stall_cnt and drain_cnt as extra outputs.
module dcache_write_buffer #(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  mem_address,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [255:0] mem_wdata,
    output logic [255:0] mem_rdata,
    output logic         mem_resp,
    output logic [31:0]  pmem_address,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [255:0] pmem_wdata,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp,
`ifdef DCACHE_WRITE_BUFFER_PERF_EN
    output logic [31:0]  read_hit_cnt,
    output logic [31:0]  full_stall_cnt,
    output logic [31:0]  drain_cnt,
`endif
    output logic         empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [26:0]      tag_q  [DEPTH];
    logic [255:0]     line_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [PW-1:0]    head_q, tail_q;
    logic [CW-1:0]    count_q;
    logic [1:0]       state_q;
    logic             rd_pend_q;
    logic [26:0]      rd_tag_q;

    logic [26:0]      req_tag;
    logic [DEPTH-1:0] hit_vec;
    logic             hit;
    logic [PW-1:0]    hit_idx;
    logic             unused_addr_lsb;

    assign req_tag         = mem_address[31:5];
    assign unused_addr_lsb = ^mem_address[4:0];

    for (genvar g = 0; g < DEPTH; g++) begin : g_match
        assign hit_vec[g] = vld_q[g] && (tag_q[g] == req_tag);
    end

    always_comb begin
        hit_idx = '0;
        for (int i = 0; i < DEPTH; i++)
            if (hit_vec[i]) hit_idx = PW'(i);
    end
    assign hit = |hit_vec;

    // The cycle carrying mem_resp still sees the previous request held high,
    // so it is ignored. A pending read miss also blocks new requests.
    logic req_ok, wr_req, rd_req, pop, head_busy, full;
    logic wr_coal, wr_alloc, full_stall, rd_hit, rd_miss;

    assign req_ok     = !mem_resp && !rd_pend_q;
    assign wr_req     = req_ok && mem_write;
    assign rd_req     = req_ok && mem_read && !mem_write;
    assign pop        = (state_q == S_DRAIN) && pmem_resp;
    // The head line is frozen while it is on the bus; a write to it waits
    // for the pop and then allocates a fresh entry.
    assign head_busy  = (state_q == S_DRAIN) && (hit_idx == head_q);
    assign full       = (count_q == CW'(DEPTH));
    assign wr_coal    = wr_req && hit && !head_busy;
    assign wr_alloc   = wr_req && !hit && !full;
    assign full_stall = wr_req && !hit && full;
    assign rd_hit     = rd_req && hit;
    assign rd_miss    = rd_req && !hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i]  <= '0;
                line_q[i] <= '0;
            end
            vld_q     <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            state_q   <= S_IDLE;
            rd_pend_q <= 1'b0;
            rd_tag_q  <= '0;
            mem_rdata <= '0;
            mem_resp  <= 1'b0;
        end else begin
            mem_resp <= 1'b0;
            if (wr_coal) begin
                line_q[hit_idx] <= mem_wdata;
                mem_resp        <= 1'b1;
            end
            // Pop and allocate never touch the same slot: allocation needs a
            // free slot, pop needs an occupied one.
            if (pop) begin
                vld_q[head_q] <= 1'b0;
                head_q        <= head_q + PW'(1);
            end
            if (wr_alloc) begin
                tag_q[tail_q]  <= req_tag;
                line_q[tail_q] <= mem_wdata;
                vld_q[tail_q]  <= 1'b1;
                tail_q         <= tail_q + PW'(1);
                mem_resp       <= 1'b1;
            end
            count_q <= count_q + CW'(wr_alloc) - CW'(pop);

            if (rd_hit) begin
                mem_rdata <= line_q[hit_idx];
                mem_resp  <= 1'b1;
            end
            if (rd_miss) begin
                rd_pend_q <= 1'b1;
                rd_tag_q  <= req_tag;
            end

            case (state_q)
                S_IDLE: begin
                    if (rd_pend_q)         state_q <= S_READ;
                    else if (count_q != 0) state_q <= S_DRAIN;
                end
                S_READ: begin
                    if (pmem_resp) begin
                        mem_rdata <= pmem_rdata;
                        mem_resp  <= 1'b1;
                        rd_pend_q <= 1'b0;
                        state_q   <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (pmem_resp) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        pmem_read    = (state_q == S_READ);
        pmem_write   = (state_q == S_DRAIN);
        pmem_address = '0;
        pmem_wdata   = '0;
        if (state_q == S_READ) begin
            pmem_address = {rd_tag_q, 5'b0};
        end else if (state_q == S_DRAIN) begin
            pmem_address = {tag_q[head_q], 5'b0};
            pmem_wdata   = line_q[head_q];
        end
    end

    assign empty = (count_q == 0) && (state_q == S_IDLE);

`ifdef DCACHE_WRITE_BUFFER_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            read_hit_cnt   <= '0;
            full_stall_cnt <= '0;
            drain_cnt      <= '0;
        end else begin
            if (rd_hit && read_hit_cnt != '1)       read_hit_cnt   <= read_hit_cnt + 32'd1;
            if (full_stall && full_stall_cnt != '1) full_stall_cnt <= full_stall_cnt + 32'd1;
            if (pop && drain_cnt != '1)             drain_cnt      <= drain_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dcache_write_buffer.sv
// Directed bench for dcache_write_buffer (DEPTH=2): a table of cache-side
// transactions with downstream blocked, plus hand-written sequences for
// drain, full stall, read priority and asynchronous reset.
module tb_dcache_write_buffer;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [31:0]  mem_address = '0;
    logic         mem_read = 1'b0;
    logic         mem_write = 1'b0;
    logic [255:0] mem_wdata = '0;
    logic [255:0] mem_rdata;
    logic         mem_resp;
    logic [31:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata = '0;
    logic         pmem_resp = 1'b0;
    logic         empty;
`ifdef DCACHE_WRITE_BUFFER_PERF_EN
    logic [31:0]  read_hit_cnt, full_stall_cnt, drain_cnt;
`endif

    dcache_write_buffer #(.DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
`ifdef DCACHE_WRITE_BUFFER_PERF_EN
        .read_hit_cnt(read_hit_cnt), .full_stall_cnt(full_stall_cnt), .drain_cnt(drain_cnt),
`endif
        .empty(empty)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int rd_seen = 0;

    always @(posedge clk) if (pmem_read) rd_seen++;

    localparam logic [255:0] LA   = {8{32'hA0A0_0001}};
    localparam logic [255:0] LB   = {8{32'hB0B0_0002}};
    localparam logic [255:0] LC   = {8{32'hC0C0_0003}};
    localparam logic [255:0] LD   = {8{32'hD0D0_0004}};
    localparam logic [255:0] LE   = {8{32'hE0E0_0005}};
    localparam logic [255:0] LF   = {8{32'hF0F0_0006}};
    localparam logic [255:0] LG   = {8{32'h1111_0007}};
    localparam logic [255:0] LH   = {8{32'h2222_0008}};
    localparam logic [255:0] LI   = {8{32'h3333_0009}};
    localparam logic [255:0] LDEA = {8{32'hDEAD_BEEF}};
    localparam logic [255:0] LL   = {8{32'h4444_000A}};

    typedef struct {
        bit           is_wr;
        logic [31:0]  addr;
        logic [255:0] wdata;
        logic [255:0] exp_rdata;
        int           exp_lat;
        string        name;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One cache request held until mem_resp; lat counts edges to resp (-1 on timeout).
    // The trailing edge consumes the response cycle.
    task automatic xact(input bit wr, input logic [31:0] a, input logic [255:0] d,
                        output int lat, output logic [255:0] rd);
        lat = -1;
        rd  = '0;
        @(negedge clk);
        mem_address = a; mem_wdata = d;
        mem_write = wr; mem_read = !wr;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (mem_resp) begin lat = i; rd = mem_rdata; break; end
        end
        mem_read = 1'b0; mem_write = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wait_pmem(input bit want_rd, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (want_rd ? pmem_read : pmem_write) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
    endtask

    task automatic pulse_resp(input logic [255:0] d);
        @(negedge clk);
        pmem_resp = 1'b1; pmem_rdata = d;
        @(posedge clk); #1;
        pmem_resp = 1'b0;
    endtask

    task automatic drain_one(input logic [31:0] a, input logic [255:0] d, input string nm);
        bit ok;
        wait_pmem(1'b0, ok);
        chk({nm, "_wr"}, 256'(ok), 256'(1));
        chk({nm, "_addr"}, 256'(pmem_address), 256'(a));
        chk({nm, "_data"}, pmem_wdata, d);
        pulse_resp('0);
    endtask

    initial begin
        int lat, cnt;
        bit ok;
        logic [255:0] rd;

        tbl[0] = '{1'b1, 32'h0000_2000, LB, '0, 1, "t_w2000"};
        tbl[1] = '{1'b0, 32'h0000_2004, '0, LB, 1, "t_r2004"};
        tbl[2] = '{1'b1, 32'h0000_3000, LC, '0, 1, "t_w3000c"};
        tbl[3] = '{1'b1, 32'h0000_3000, LD, '0, 1, "t_w3000d"};
        tbl[4] = '{1'b0, 32'h0000_3008, '0, LD, 1, "t_r3008"};
        tbl[5] = '{1'b0, 32'h0000_201F, '0, LB, 1, "t_r201f"};

        // reset state
        #2;
        chk("rst_resp",  256'(mem_resp), 256'(0));
        chk("rst_rdata", mem_rdata, '0);
        chk("rst_pw",    256'(pmem_write), 256'(0));
        chk("rst_pr",    256'(pmem_read), 256'(0));
        chk("rst_paddr", 256'(pmem_address), 256'(0));
        chk("rst_empty", 256'(empty), 256'(1));
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        // single posted write then drain held for 20 cycles
        xact(1'b1, 32'h0000_1040, LA, lat, rd);
        chk("w1040_lat", 256'(lat), 256'(1));
        wait_pmem(1'b0, ok);
        chk("w1040_drain", 256'(ok), 256'(1));
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (!pmem_write || pmem_address != 32'h0000_1040 || pmem_wdata != LA || pmem_read) cnt++;
            @(posedge clk); #1;
        end
        chk("w1040_hold", 256'(cnt), 256'(0));
        pulse_resp('0);
        chk("w1040_empty", 256'(empty), 256'(1));
        chk("w1040_pwoff", 256'(pmem_write), 256'(0));

        // table: downstream blocked, hits and coalescing served from the buffer
        rd_seen = 0;
        for (int v = 0; v < 6; v++) begin
            xact(tbl[v].is_wr, tbl[v].addr, tbl[v].wdata, lat, rd);
            chk({tbl[v].name, "_lat"}, 256'(lat), 256'(tbl[v].exp_lat));
            if (!tbl[v].is_wr) chk({tbl[v].name, "_rdata"}, rd, tbl[v].exp_rdata);
        end
        chk("t_no_pread", 256'(rd_seen), 256'(0));
        drain_one(32'h0000_2000, LB, "t_dr2000");
        drain_one(32'h0000_3000, LD, "t_dr3000");
        chk("t_empty", 256'(empty), 256'(1));

        // full buffer: third write stalls until the head pops
        xact(1'b1, 32'h0000_0100, LG, lat, rd);
        chk("f_w100_lat", 256'(lat), 256'(1));
        xact(1'b1, 32'h0000_0200, LH, lat, rd);
        chk("f_w200_lat", 256'(lat), 256'(1));
        @(negedge clk);
        mem_address = 32'h0000_0300; mem_wdata = LI; mem_write = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (mem_resp || pmem_address != 32'h0000_0100 || !pmem_write) cnt++;
        end
        chk("f_stall", 256'(cnt), 256'(0));
        pulse_resp('0);
        chk("f_noresp_pop", 256'(mem_resp), 256'(0));
        lat = -1;
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk); #1;
            if (mem_resp) begin lat = i; break; end
        end
        chk("f_w300_lat", 256'(lat), 256'(1));
        mem_write = 1'b0;
        @(posedge clk); #1;
        drain_one(32'h0000_0200, LH, "f_dr200");
        drain_one(32'h0000_0300, LI, "f_dr300");
        chk("f_empty", 256'(empty), 256'(1));

        // read miss waits out the current drain, then beats the next drain
        xact(1'b1, 32'h0000_0100, LE, lat, rd);
        xact(1'b1, 32'h0000_0180, LF, lat, rd);
        chk("p_w180_lat", 256'(lat), 256'(1));
        @(negedge clk);
        mem_address = 32'h0000_0400; mem_read = 1'b1;
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (pmem_read || !pmem_write || pmem_address != 32'h0000_0100) cnt++;
        end
        chk("p_drain_kept", 256'(cnt), 256'(0));
        pulse_resp('0);
        chk("p_gap", 256'({pmem_read, pmem_write, mem_resp}), 256'(0));
        @(posedge clk); #1;
        chk("p_pread", 256'({pmem_read, pmem_write}), 256'(2'b10));
        chk("p_paddr", 256'(pmem_address), 256'(32'h0000_0400));
        pulse_resp(LDEA);
        chk("p_resp", 256'(mem_resp), 256'(1));
        chk("p_rdata", mem_rdata, LDEA);
        mem_read = 1'b0;
        @(posedge clk); #1;
        drain_one(32'h0000_0180, LF, "p_dr180");
        chk("p_empty", 256'(empty), 256'(1));

        // asynchronous reset in the middle of a drain
        xact(1'b1, 32'h0000_0600, LC, lat, rd);
        xact(1'b1, 32'h0000_0700, LD, lat, rd);
        wait_pmem(1'b0, ok);
        chk("r_draining", 256'(ok), 256'(1));
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        chk("r_pw", 256'(pmem_write), 256'(0));
        chk("r_empty", 256'(empty), 256'(1));
        chk("r_resp", 256'(mem_resp), 256'(0));
        chk("r_paddr", 256'(pmem_address), 256'(0));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        mem_address = 32'h0000_0600; mem_read = 1'b1;
        @(posedge clk); #1;
        wait_pmem(1'b1, ok);
        chk("r_miss_pread", 256'(ok), 256'(1));
        chk("r_miss_addr", 256'(pmem_address), 256'(32'h0000_0600));
        pulse_resp(LL);
        chk("r_miss_resp", 256'(mem_resp), 256'(1));
        chk("r_miss_rdata", mem_rdata, LL);
        mem_read = 1'b0;
        @(posedge clk); #1;
        chk("r_final_empty", 256'(empty), 256'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
